// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central sequencer for the 5-stage core.
// Merges the decode load-use stall, EX branch resolution and memory-stage busy into per-stage
// enables and flushes, and runs the interrupt entry sequence:
//     drain -> push PC -> push flags -> vector.
//
// Ports:
//   clk, rst_n         core clock; asynchronous active-low reset
//   i_hazard_stall     load-use stall request from the decode hazard unit
//   i_branch_taken     EX resolved a taken branch/jump/call/ret
//   i_mem_busy         memory-stage access not complete
//   i_int_req          external interrupt (level)
//   i_rti_ex           RTI instruction in EX
//   o_en_f..o_en_w     pipeline register enables (PC, IF/ID, ID/EX, EX/MEM, MEM/WB)
//   o_flush_d/e        load a bubble into IF/ID / ID/EX
//   o_pc_sel           00 sequential, 01 branch target, 10 interrupt vector, 11 hold
//   o_int_push         00 none, 01 push PC, 10 push flags
//   o_int_ack          one-cycle pulse at vector fetch
//   o_int_mode         handler executing (registered)
//
// Build option NESTED_INT_EN: a 2-bit depth counter allows up to three nested handlers.
// Without it, a single interrupt level is supported.
module pipe_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_hazard_stall,
    input  logic       i_branch_taken,
    input  logic       i_mem_busy,
    input  logic       i_int_req,
    input  logic       i_rti_ex,
    output logic       o_en_f,
    output logic       o_en_d,
    output logic       o_en_e,
    output logic       o_en_m,
    output logic       o_en_w,
    output logic       o_flush_d,
    output logic       o_flush_e,
    output logic [1:0] o_pc_sel,
    output logic [1:0] o_int_push,
    output logic       o_int_ack,
    output logic       o_int_mode
);

    typedef enum logic [2:0] {
        StRun,
        StDrain,
        StPushPc,
        StPushFlags,
        StVector
    } state_e;

    localparam logic [CNT_W-1:0] DrainLoad = CNT_W'(DRAIN_CYCLES - 1);

    state_e           r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next, w_cnt_dec;
    logic             w_int_ok;    // an interrupt may be accepted now
    logic             w_rti_qual;  // RTI retires this cycle
    logic             w_vector;
    logic             w_freeze;    // whole pipe holds
    logic             w_stall;     // front end holds, bubble enters EX
    logic             w_flush_all; // bubble into both IF/ID and ID/EX

    assign w_cnt_dec = r_cnt - CNT_W'(1);
    // RTI completes once EX can advance; a taken RTI is its own branch and retires with it.
    assign w_rti_qual = i_rti_ex & (i_branch_taken | ~i_mem_busy);

`ifdef NESTED_INT_EN
    logic [1:0] r_depth, w_depth_next;

    assign w_int_ok   = (r_depth != 2'd3);
    assign o_int_mode = (r_depth != 2'd0);

    always_comb begin
        w_depth_next = r_depth;
        if (w_vector) begin
            w_depth_next = r_depth + 2'd1;
        end else if (w_rti_qual && r_depth != 2'd0) begin
            w_depth_next = r_depth - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_depth <= 2'd0;
        end else begin
            r_depth <= w_depth_next;
        end
    end
`else
    logic r_int_mode, w_int_mode_next;

    assign w_int_ok   = ~r_int_mode;
    assign o_int_mode = r_int_mode;

    always_comb begin
        w_int_mode_next = r_int_mode;
        if (w_vector) begin
            w_int_mode_next = 1'b1;
        end else if (w_rti_qual) begin
            w_int_mode_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_int_mode <= 1'b0;
        end else begin
            r_int_mode <= w_int_mode_next;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StRun;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_vector     = 1'b0;
        w_freeze     = 1'b0;
        w_stall      = 1'b0;
        w_flush_all  = 1'b0;
        o_pc_sel     = 2'b00;
        o_int_push   = 2'b00;
        o_int_ack    = 1'b0;

        unique case (r_state)
            StRun: begin
                if (i_mem_busy) begin
                    w_freeze = 1'b1;
                end else if (i_branch_taken) begin
                    w_flush_all = 1'b1;
                    o_pc_sel    = 2'b01;
                end else if (i_int_req && w_int_ok) begin
                    // The accept cycle is the first drain cycle.
                    w_stall = 1'b1;
                    if (DRAIN_CYCLES == 1) begin
                        w_state_next = StPushPc;
                    end else begin
                        w_state_next = StDrain;
                        w_cnt_next   = DrainLoad;
                    end
                end else if (i_hazard_stall) begin
                    w_stall = 1'b1;
                end
            end
            StDrain: begin
                if (i_mem_busy) begin
                    w_freeze = 1'b1;
                end else begin
                    w_stall    = 1'b1;
                    w_cnt_next = w_cnt_dec;
                    if (w_cnt_dec == '0) begin
                        w_state_next = StPushPc;
                    end
                end
            end
            StPushPc, StPushFlags: begin
                o_int_push = (r_state == StPushPc) ? 2'b01 : 2'b10;
                if (i_mem_busy) begin
                    w_freeze = 1'b1;
                end else begin
                    w_stall      = 1'b1;
                    w_state_next = (r_state == StPushPc) ? StPushFlags : StVector;
                end
            end
            StVector: begin
                w_vector     = 1'b1;
                w_flush_all  = 1'b1;
                o_pc_sel     = 2'b10;
                o_int_ack    = 1'b1;
                w_state_next = StRun;
            end
            default: begin
                w_state_next = StRun;
            end
        endcase

        if (w_freeze || w_stall) begin
            o_pc_sel = 2'b11;
        end
        o_en_f    = ~w_freeze & ~w_stall;
        o_en_d    = ~w_freeze & ~w_stall;
        o_en_e    = ~w_freeze;
        o_en_m    = ~w_freeze;
        o_en_w    = ~w_freeze;
        o_flush_d = w_flush_all;
        o_flush_e = w_flush_all | w_stall;

        // Reset holds every stage and keeps bubbles loaded.
        if (!rst_n) begin
            o_en_f     = 1'b0;
            o_en_d     = 1'b0;
            o_en_e     = 1'b0;
            o_en_m     = 1'b0;
            o_en_w     = 1'b0;
            o_flush_d  = 1'b1;
            o_flush_e  = 1'b1;
            o_pc_sel   = 2'b00;
            o_int_push = 2'b00;
            o_int_ack  = 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with fixed expectations plus a randomized run checked
// against a queue-based model of the interrupt entry sequence.
module tb_pipe_ctrl;

    localparam int unsigned DrainCycles = 3;
`ifdef NESTED_INT_EN
    localparam int MaxDepth = 3;
`else
    localparam int MaxDepth = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hz = 1'b0, br = 1'b0, mb = 1'b0, ir = 1'b0, rti = 1'b0;
    logic en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, int_ack, int_mode;
    logic [1:0] pc_sel, int_push;
    logic [12:0] obs;

    int checks = 0;
    int failures = 0;

    // Model: pending phases of the interrupt sequence (0 drain, 1 push PC, 2 push flags,
    // 3 vector) and the current handler depth.
    int q[$];
    int depth = 0;
    logic [12:0] exp_v;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .DRAIN_CYCLES(DrainCycles),
        .CNT_W       (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_hazard_stall(hz),
        .i_branch_taken(br),
        .i_mem_busy    (mb),
        .i_int_req     (ir),
        .i_rti_ex      (rti),
        .o_en_f        (en_f),
        .o_en_d        (en_d),
        .o_en_e        (en_e),
        .o_en_m        (en_m),
        .o_en_w        (en_w),
        .o_flush_d     (flush_d),
        .o_flush_e     (flush_e),
        .o_pc_sel      (pc_sel),
        .o_int_push    (int_push),
        .o_int_ack     (int_ack),
        .o_int_mode    (int_mode)
    );

    // {en_f,en_d,en_e,en_m,en_w, flush_d,flush_e, pc_sel, int_push, int_ack, int_mode}
    assign obs = {en_f, en_d, en_e, en_m, en_w, flush_d, flush_e, pc_sel, int_push,
                  int_ack, int_mode};

    task automatic tick();
        @(negedge clk);
    endtask

    // Apply one cycle of inputs, predict outputs into exp_v, advance the model, let outputs settle.
    task automatic drive(input logic r, input logic h, input logic b, input logic m,
                         input logic irq, input logic rt);
        logic [4:0] en;
        logic       fd, fe, ack;
        logic [1:0] sel, push;
        int         ph;
        rst_n = r; hz = h; br = b; mb = m; ir = irq; rti = rt;
        if (!r) begin
            q.delete();
            depth = 0;
            exp_v = 13'b00000_11_00_00_0_0;
        end else begin
            en = 5'b11111; fd = 1'b0; fe = 1'b0; sel = 2'b00; push = 2'b00; ack = 1'b0;
            ph = -1;
            if (q.size() == 0) begin
                if (m) begin
                    en = 5'b00000; sel = 2'b11;
                end else if (b) begin
                    fd = 1'b1; fe = 1'b1; sel = 2'b01;
                end else if (irq && depth < MaxDepth) begin
                    en = 5'b00111; fe = 1'b1; sel = 2'b11;
                    for (int k = 1; k < DrainCycles; k++) q.push_back(0);
                    q.push_back(1);
                    q.push_back(2);
                    q.push_back(3);
                end else if (h) begin
                    en = 5'b00111; fe = 1'b1; sel = 2'b11;
                end
            end else begin
                ph = q[0];
                if (ph == 3) begin
                    fd = 1'b1; fe = 1'b1; sel = 2'b10; ack = 1'b1;
                    q.delete(0);
                end else begin
                    push = (ph == 1) ? 2'b01 : (ph == 2) ? 2'b10 : 2'b00;
                    if (m) begin
                        en = 5'b00000; sel = 2'b11;
                    end else begin
                        en = 5'b00111; fe = 1'b1; sel = 2'b11;
                        q.delete(0);
                    end
                end
            end
            exp_v = {en, fd, fe, sel, push, ack, (depth != 0)};
            if (ph == 3) depth++;
            else if (rt && (b || !m) && depth > 0) depth--;
        end
        #2;
    endtask

    task automatic test_reset();
        logic [12:0] want;
        want = 13'b00000_11_00_00_0_0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checks++;
            if (obs !== want) begin
                failures++; $display("FAIL reset_hold: got %b want %b", obs, want);
            end
            tick();
        end
        drive(1'b1, 0, 0, 0, 0, 0);
        want = 13'b11111_00_00_00_0_0;
        checks++;
        if (obs !== want) begin
            failures++; $display("FAIL reset_release: got %b want %b", obs, want);
        end
        tick();
    endtask

    task automatic test_stall_branch();
        logic [12:0] want;
        drive(1'b1, 1, 0, 0, 0, 0);
        want = 13'b00111_01_11_00_0_0;
        checks++;
        if (obs !== want) begin
            failures++; $display("FAIL load_use: got %b want %b", obs, want);
        end
        tick();
        drive(1'b1, 1, 1, 0, 0, 0);
        want = 13'b11111_11_01_00_0_0;
        checks++;
        if (obs !== want) begin
            failures++; $display("FAIL branch_over_stall: got %b want %b", obs, want);
        end
        tick();
        drive(1'b1, 0, 0, 0, 0, 0);
        want = 13'b11111_00_00_00_0_0;
        checks++;
        if (obs !== want) begin
            failures++; $display("FAIL run_after_branch: got %b want %b", obs, want);
        end
        tick();
    endtask

    task automatic test_mem_freeze();
        logic [12:0] want;
        want = 13'b00000_00_11_00_0_0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1, 0, 1, 0, 0);
            checks++;
            if (obs !== want) begin
                failures++; $display("FAIL mem_freeze[%0d]: got %b want %b", i, obs, want);
            end
            tick();
        end
        drive(1'b1, 1, 0, 0, 0, 0);
        want = 13'b00111_01_11_00_0_0;
        checks++;
        if (obs !== want) begin
            failures++; $display("FAIL stall_after_freeze: got %b want %b", obs, want);
        end
        tick();
    endtask

    task automatic test_int_entry();
        logic [12:0] want;
        want = 13'b00111_01_11_00_0_0;
        for (int i = 0; i < int'(DrainCycles); i++) begin
            drive(1'b1, 0, 0, 0, (i == 0), 0);
            checks++;
            if (obs !== want) begin
                failures++; $display("FAIL int_drain[%0d]: got %b want %b", i, obs, want);
            end
            tick();
        end
        drive(1'b1, 0, 0, 0, 0, 0);
        want = 13'b00111_01_11_01_0_0;
        checks++;
        if (obs !== want) begin
            failures++; $display("FAIL int_push_pc: got %b want %b", obs, want);
        end
        tick();
        drive(1'b1, 0, 0, 0, 0, 0);
        want = 13'b00111_01_11_10_0_0;
        checks++;
        if (obs !== want) begin
            failures++; $display("FAIL int_push_flags: got %b want %b", obs, want);
        end
        tick();
        drive(1'b1, 0, 0, 0, 0, 0);
        want = 13'b11111_11_10_00_1_0;
        checks++;
        if (obs !== want) begin
            failures++; $display("FAIL int_vector: got %b want %b", obs, want);
        end
        tick();
        drive(1'b1, 0, 0, 0, 0, 0);
        want = 13'b11111_00_00_00_0_1;
        checks++;
        if (obs !== want) begin
            failures++; $display("FAIL int_mode_set: got %b want %b", obs, want);
        end
        tick();
    endtask

    task automatic test_handler_exit();
        logic [12:0] want;
        want = 13'b11111_00_00_00_0_1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 0, 0, 0, (i == 0), 0);
            checks++;
            if (obs !== want) begin
                failures++; $display("FAIL int_ignored[%0d]: got %b want %b", i, obs, want);
            end
            tick();
        end
        drive(1'b1, 0, 0, 0, 0, 1);
        checks++;
        if (obs !== want) begin
            failures++; $display("FAIL rti_cycle: got %b want %b", obs, want);
        end
        tick();
        drive(1'b1, 0, 0, 0, 0, 0);
        want = 13'b11111_00_00_00_0_0;
        checks++;
        if (obs !== want) begin
            failures++; $display("FAIL rti_clears_mode: got %b want %b", obs, want);
        end
        tick();
        // Re-enter, then reset during the flags push.
        for (int i = 0; i < int'(DrainCycles) + 1; i++) begin
            drive(1'b1, 0, 0, 0, (i == 0), 0);
            tick();
        end
        drive(1'b1, 0, 0, 0, 0, 0);
        want = 13'b00111_01_11_10_0_0;
        checks++;
        if (obs !== want) begin
            failures++; $display("FAIL reentry_push_flags: got %b want %b", obs, want);
        end
        drive(1'b0, 0, 0, 0, 0, 0);
        want = 13'b00000_11_00_00_0_0;
        checks++;
        if (obs !== want) begin
            failures++; $display("FAIL reset_mid_seq: got %b want %b", obs, want);
        end
        tick();
        want = 13'b11111_00_00_00_0_0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 0, 0, 0, 0, 0);
            checks++;
            if (obs !== want) begin
                failures++; $display("FAIL run_after_abort[%0d]: got %b want %b", i, obs, want);
            end
            tick();
        end
    endtask

    task automatic test_int_interactions();
        logic [12:0] want;
        drive(1'b1, 0, 1, 0, 1, 0);
        want = 13'b11111_11_01_00_0_0;
        checks++;
        if (obs !== want) begin
            failures++; $display("FAIL int_with_branch: got %b want %b", obs, want);
        end
        tick();
        want = 13'b00111_01_11_00_0_0;
        for (int i = 0; i < int'(DrainCycles); i++) begin
            drive(1'b1, 0, 0, 0, (i == 0), 0);
            checks++;
            if (obs !== want) begin
                failures++; $display("FAIL late_drain[%0d]: got %b want %b", i, obs, want);
            end
            tick();
        end
        want = 13'b00000_00_11_01_0_0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 0, 0, 1, 0, 0);
            checks++;
            if (obs !== want) begin
                failures++; $display("FAIL push_pc_busy[%0d]: got %b want %b", i, obs, want);
            end
            tick();
        end
        drive(1'b1, 0, 0, 0, 0, 0);
        want = 13'b00111_01_11_01_0_0;
        checks++;
        if (obs !== want) begin
            failures++; $display("FAIL push_pc_release: got %b want %b", obs, want);
        end
        tick();
        drive(1'b1, 0, 0, 0, 0, 0);
        want = 13'b00111_01_11_10_0_0;
        checks++;
        if (obs !== want) begin
            failures++; $display("FAIL push_flags2: got %b want %b", obs, want);
        end
        tick();
        drive(1'b1, 0, 0, 0, 0, 0);
        want = 13'b11111_11_10_00_1_0;
        checks++;
        if (obs !== want) begin
            failures++; $display("FAIL vector2: got %b want %b", obs, want);
        end
        tick();
        drive(1'b1, 0, 1, 0, 0, 1);
        want = 13'b11111_11_01_00_0_1;
        checks++;
        if (obs !== want) begin
            failures++; $display("FAIL rti_branch: got %b want %b", obs, want);
        end
        tick();
        drive(1'b1, 0, 0, 0, 0, 0);
        want = 13'b11111_00_00_00_0_0;
        checks++;
        if (obs !== want) begin
            failures++; $display("FAIL rti_branch_clears: got %b want %b", obs, want);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 149) != 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL random[%0d] in=%b%b%b%b%b%b: got %b want %b", i, rst_n, hz, br,
                         mb, ir, rti, obs, exp_v);
            end
            tick();
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_stall_branch();
        test_mem_freeze();
        test_int_entry();
        test_handler_exit();
        test_int_interactions();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
